// File: rtl/pulse_pkg.sv
// Shared widths, field indices and the pulse word layout for the pulse command queue.
package pulse_pkg;

    localparam int unsigned PHASE_W = 17;
    localparam int unsigned FREQ_W  = 9;
    localparam int unsigned AMP_W   = 16;
    localparam int unsigned ENV_W   = 24;
    localparam int unsigned CFG_W   = 4;

    localparam int unsigned PULSE_WORD_WIDTH = PHASE_W + FREQ_W + AMP_W + ENV_W + CFG_W;

    localparam int unsigned FLD_PHASE = 0;
    localparam int unsigned FLD_FREQ  = 1;
    localparam int unsigned FLD_AMP   = 2;
    localparam int unsigned FLD_ENV   = 3;
    localparam int unsigned FLD_CFG   = 4;
    localparam int unsigned NUM_FLDS  = 5;

    typedef struct packed {
        logic [PHASE_W-1:0] phase;
        logic [FREQ_W-1:0]  freq;
        logic [AMP_W-1:0]   amp;
        logic [ENV_W-1:0]   env_word;
        logic [CFG_W-1:0]   cfg;
    } pulse_word_t;

endpackage

// File: rtl/pulse_word_fifo.sv
// First-word-fall-through sync FIFO on a register array; dout holds the last
// popped word while empty.
module pulse_word_fifo #(
    parameter int unsigned WIDTH     = 70,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic                 full,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0]     dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 full_q, full_d;
    logic                 pop_ok, push_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        pop_ok   = pop && valid_q && !flush;
        push_ok  = push && !flush && (!full_q || pop_ok);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end

        // Register the next head; a word pushed into an empty slot at the head falls through from din.
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_ptr_d];
            end
        end

        valid_d = (count_d != '0);
        full_d  = (count_d == CNT_WIDTH'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
        end
    end

    assign dout  = dout_q;
    assign valid = valid_q;
    assign full  = full_q;
    assign count = count_q;

endmodule

// File: rtl/pulse_cmd_queue.sv
// Processor-to-DSP pulse interface: sticky per-field staging, commit merge,
// push qualification and overflow tracking in front of a pulse word FIFO.
module pulse_cmd_queue
    import pulse_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH    = PHASE_W,
    parameter int unsigned FREQ_WIDTH     = FREQ_W,
    parameter int unsigned AMP_WIDTH      = AMP_W,
    parameter int unsigned CFG_WIDTH      = CFG_W,
    parameter int unsigned ENV_WORD_WIDTH = ENV_W,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [PHASE_WIDTH-1:0]    in_phase,
    input  logic [FREQ_WIDTH-1:0]     in_freq,
    input  logic [AMP_WIDTH-1:0]      in_amp,
    input  logic [ENV_WORD_WIDTH-1:0] in_env_word,
    input  logic [CFG_WIDTH-1:0]      in_cfg,
    input  logic [NUM_FLDS-1:0]       field_we,
    input  logic                      cstrobe,
    input  logic                      flush,
    output logic [PHASE_WIDTH-1:0]    out_phase,
    output logic [FREQ_WIDTH-1:0]     out_freq,
    output logic [AMP_WIDTH-1:0]      out_amp,
    output logic [ENV_WORD_WIDTH-1:0] out_env_word,
    output logic [CFG_WIDTH-1:0]      out_cfg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_WIDTH-1:0]      count,
    output logic                      full,
    output logic                      overflow
);

    localparam int unsigned WORD_W = PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH
                                   + ENV_WORD_WIDTH + CFG_WIDTH;

    logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
    logic [FREQ_WIDTH-1:0]     freq_q, freq_d;
    logic [AMP_WIDTH-1:0]      amp_q, amp_d;
    logic [ENV_WORD_WIDTH-1:0] env_q, env_d;
    logic [CFG_WIDTH-1:0]      cfg_q, cfg_d;
    logic                      overflow_q, overflow_d;
    logic [WORD_W-1:0]         commit_word;
    logic [WORD_W-1:0]         head_word;
    logic                      fifo_valid, fifo_full;
    logic                      pop, push, drop;

    // The next staging value is exactly the merged commit word, so a cstrobe sees same-cycle writes.
    always_comb begin
        phase_d = field_we[FLD_PHASE] ? in_phase    : phase_q;
        freq_d  = field_we[FLD_FREQ]  ? in_freq     : freq_q;
        amp_d   = field_we[FLD_AMP]   ? in_amp      : amp_q;
        env_d   = field_we[FLD_ENV]   ? in_env_word : env_q;
        cfg_d   = field_we[FLD_CFG]   ? in_cfg      : cfg_q;
        commit_word = {phase_d, freq_d, amp_d, env_d, cfg_d};
    end

    always_comb begin
        pop        = fifo_valid && out_ready;
        push       = cstrobe && !flush && (!fifo_full || pop);
        drop       = cstrobe && fifo_full && !pop && !flush;
        overflow_d = flush ? 1'b0 : (overflow_q || drop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= '0;
            freq_q     <= '0;
            amp_q      <= '0;
            env_q      <= '0;
            cfg_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            freq_q     <= freq_d;
            amp_q      <= amp_d;
            env_q      <= env_d;
            cfg_q      <= cfg_d;
            overflow_q <= overflow_d;
        end
    end

    pulse_word_fifo #(
        .WIDTH     (WORD_W),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (commit_word),
        .dout  (head_word),
        .valid (fifo_valid),
        .full  (fifo_full),
        .count (count)
    );

    assign {out_phase, out_freq, out_amp, out_env_word, out_cfg} = head_word;
    assign out_valid = fifo_valid;
    assign full      = fifo_full;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_cmd_queue.sv
// Directed bench for pulse_cmd_queue: staging, ordering, full/overflow, wrap, flush, reset.
module tb_pulse_cmd_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] in_phase;
    logic [8:0]  in_freq;
    logic [15:0] in_amp;
    logic [23:0] in_env_word;
    logic [3:0]  in_cfg;
    logic [4:0]  field_we;
    logic        cstrobe;
    logic        flush;
    logic [16:0] out_phase;
    logic [8:0]  out_freq;
    logic [15:0] out_amp;
    logic [23:0] out_env_word;
    logic [3:0]  out_cfg;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  count;
    logic        full;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    pulse_cmd_queue dut (
        .clk          (clk),
        .reset        (reset),
        .in_phase     (in_phase),
        .in_freq      (in_freq),
        .in_amp       (in_amp),
        .in_env_word  (in_env_word),
        .in_cfg       (in_cfg),
        .field_we     (field_we),
        .cstrobe      (cstrobe),
        .flush        (flush),
        .out_phase    (out_phase),
        .out_freq     (out_freq),
        .out_amp      (out_amp),
        .out_env_word (out_env_word),
        .out_cfg      (out_cfg),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .overflow     (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One commit that rewrites only the amplitude field.
    task automatic commit_amp(input logic [15:0] amp);
        field_we = 5'b00100;
        in_amp   = amp;
        cstrobe  = 1'b1;
        step();
        cstrobe  = 1'b0;
        field_we = 5'b00000;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] amp);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_amp"}, 32'(out_amp), 32'(amp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_phase = '0; in_freq = '0; in_amp = '0; in_env_word = '0;
        in_cfg = '0; field_we = '0; cstrobe = 1'b0; flush = 1'b0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_amp", 32'(out_amp), 32'd0);

        // Staging and merge
        field_we = 5'b11111; in_phase = 17'h1ABCD; in_freq = 9'h055; in_amp = 16'h7FFF;
        in_env_word = 24'h010020; in_cfg = 4'h3; cstrobe = 1'b1;
        step();
        cstrobe = 1'b0; field_we = 5'b00000;
        check("m1_valid", 32'(out_valid), 32'd1);
        check("m1_phase", 32'(out_phase), 32'h1ABCD);
        check("m1_freq", 32'(out_freq), 32'h055);
        check("m1_amp", 32'(out_amp), 32'h7FFF);
        check("m1_env", 32'(out_env_word), 32'h010020);
        check("m1_cfg", 32'(out_cfg), 32'h3);
        check("m1_count", 32'(count), 32'd1);
        commit_amp(16'h1000);
        check("m2_count", 32'(count), 32'd2);
        pop_check("m_pop1", 16'h7FFF);
        check("m2_phase", 32'(out_phase), 32'h1ABCD);
        check("m2_env", 32'(out_env_word), 32'h010020);
        check("m2_cfg", 32'(out_cfg), 32'h3);
        pop_check("m_pop2", 16'h1000);
        check("m_empty_valid", 32'(out_valid), 32'd0);
        check("m_empty_hold", 32'(out_amp), 32'h1000);

        // Latency and ordering
        commit_amp(16'd1); check("l_cnt1", 32'(count), 32'd1);
        commit_amp(16'd2); check("l_cnt2", 32'(count), 32'd2);
        commit_amp(16'd3); check("l_cnt3", 32'(count), 32'd3);
        pop_check("l_pop1", 16'd1);
        pop_check("l_pop2", 16'd2);
        pop_check("l_pop3", 16'd3);
        check("l_drop_valid", 32'(out_valid), 32'd0);

        // Full and overflow
        for (int i = 0; i < 8; i++) commit_amp(16'(16'h10 + i));
        check("f_full", 32'(full), 32'd1);
        check("f_count", 32'(count), 32'd8);
        check("f_ovf0", 32'(overflow), 32'd0);
        commit_amp(16'h0099);
        check("f_ovf1", 32'(overflow), 32'd1);
        check("f_count9", 32'(count), 32'd8);
        check("f_head9", 32'(out_amp), 32'h10);
        out_ready = 1'b1;
        commit_amp(16'h00AA);
        out_ready = 1'b0;
        check("f_count10", 32'(count), 32'd8);
        check("f_head10", 32'(out_amp), 32'h11);
        check("f_full10", 32'(full), 32'd1);
        for (int i = 1; i < 8; i++) pop_check("f_drain", 16'(16'h10 + i));
        pop_check("f_drain_aa", 16'h00AA);
        check("f_empty", 32'(out_valid), 32'd0);
        check("f_ovf_sticky", 32'(overflow), 32'd1);

        // Wrap-around: 20 commits, 16 of them paired with a pop
        for (int i = 0; i < 4; i++) begin
            commit_amp(16'(16'h100 + i));
            exp_q.push_back(16'(16'h100 + i));
        end
        for (int i = 4; i < 20; i++) begin
            check("w_head", 32'(out_amp), 32'(exp_q.pop_front()));
            out_ready = 1'b1;
            commit_amp(16'(16'h100 + i));
            out_ready = 1'b0;
            exp_q.push_back(16'(16'h100 + i));
            check("w_count", 32'(count), 32'd4);
        end
        while (exp_q.size() > 0) pop_check("w_drain", exp_q.pop_front());
        check("w_empty", 32'(out_valid), 32'd0);

        // Flush priority over commit and pop; staging survives
        for (int i = 1; i <= 4; i++) commit_amp(16'(16'h40 + i));
        check("fl_count4", 32'(count), 32'd4);
        check("fl_ovf_pre", 32'(overflow), 32'd1);
        flush = 1'b1; cstrobe = 1'b1; out_ready = 1'b1;
        step();
        flush = 1'b0; cstrobe = 1'b0; out_ready = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_ovf", 32'(overflow), 32'd0);
        check("fl_valid", 32'(out_valid), 32'd0);
        cstrobe = 1'b1;
        step();
        cstrobe = 1'b0;
        check("fl_restage_cnt", 32'(count), 32'd1);
        check("fl_restage_phase", 32'(out_phase), 32'h1ABCD);
        check("fl_restage_env", 32'(out_env_word), 32'h010020);
        pop_check("fl_restage", 16'h0044);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) commit_amp(16'(16'h50 + i));
        field_we = 5'b00100; in_amp = 16'h2222;
        step();
        field_we = 5'b00000;
        check("r_count5", 32'(count), 32'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("r_valid", 32'(out_valid), 32'd0);
        check("r_count", 32'(count), 32'd0);
        check("r_full", 32'(full), 32'd0);
        check("r_ovf", 32'(overflow), 32'd0);
        check("r_amp", 32'(out_amp), 32'd0);
        check("r_phase", 32'(out_phase), 32'd0);
        cstrobe = 1'b1;
        step();
        cstrobe = 1'b0;
        check("r_q_valid", 32'(out_valid), 32'd1);
        check("r_q_count", 32'(count), 32'd1);
        check("r_q_amp", 32'(out_amp), 32'd0);
        check("r_q_phase", 32'(out_phase), 32'd0);
        check("r_q_freq", 32'(out_freq), 32'd0);
        check("r_q_env", 32'(out_env_word), 32'd0);
        check("r_q_cfg", 32'(out_cfg), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
